// File: rtl/mipi_hs_serializer.sv
// rtl/mipi_hs_serializer.sv - 8:1 MIPI D-PHY HS transmit serializer
//
// Frames parallel bytes into one HS burst, LSB first:
//   HS-zero (HS_ZERO_CYC zeros), SoT sync byte, payload bytes, HS-trail.
// One serial bit leaves on DTXHSP per rising edge of TxDDRClkHS.
//
// Ports:
//   TxDDRClkHS  in   HS bit clock
//   RST_N       in   asynchronous active-low reset
//   HS_SER_EN   in   burst request, sampled only while idle
//   TXDATA      in   payload byte, bit 0 transmitted first
//   TXVALID     in   TXDATA holds a valid byte
//   TXREADY     out  byte slot open (last bit of current byte on the wire)
//   DTXHSP      out  registered serial HS data
//   HS_ACTIVE   out  registered HS drive enable
//
// DTXHSP always shows the bit currently on the wire; bit_cnt is the index of
// that bit within its byte and sh holds the bits of that byte still to go.
// Each state transition therefore also emits the first bit of the next phase,
// which is what keeps the burst free of bubbles.
module mipi_hs_serializer #(
  parameter int               WIDTH        = 8,
  parameter logic [7:0]       HS_ZERO_CYC  = 8'd16,
  parameter logic [7:0]       HS_TRAIL_CYC = 8'd8,
  parameter logic [WIDTH-1:0] SYNC_BYTE    = 8'hB8
) (
  input  logic             TxDDRClkHS,
  input  logic             RST_N,
  input  logic             HS_SER_EN,
  input  logic [WIDTH-1:0] TXDATA,
  input  logic             TXVALID,
  output logic             TXREADY,
  output logic             DTXHSP,
  output logic             HS_ACTIVE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       len_cnt, len_cnt_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic             dout_nxt;
  logic             active_nxt;
  logic             trail_lvl, trail_lvl_nxt;

  // Slot is open while the last bit of the sync or a payload byte is driven.
  assign TXREADY = ((state == S_SYNC) || (state == S_DATA)) && (bit_cnt == 3'd7);

  always_ff @(posedge TxDDRClkHS or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      len_cnt   <= 8'd0;
      sh        <= '0;
      DTXHSP    <= 1'b0;
      HS_ACTIVE <= 1'b0;
      trail_lvl <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      len_cnt   <= len_cnt_nxt;
      sh        <= sh_nxt;
      DTXHSP    <= dout_nxt;
      HS_ACTIVE <= active_nxt;
      trail_lvl <= trail_lvl_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    len_cnt_nxt   = len_cnt;
    sh_nxt        = sh;
    dout_nxt      = DTXHSP;
    active_nxt    = HS_ACTIVE;
    trail_lvl_nxt = trail_lvl;

    case (state)
      S_IDLE: begin
        dout_nxt   = 1'b0;
        active_nxt = 1'b0;
        if (HS_SER_EN) begin
          // This edge already drives the first HS-zero bit.
          state_nxt   = S_ZERO;
          active_nxt  = 1'b1;
          len_cnt_nxt = 8'd1;
        end
      end

      S_ZERO: begin
        if (len_cnt == HS_ZERO_CYC) begin
          state_nxt   = S_SYNC;
          dout_nxt    = SYNC_BYTE[0];
          sh_nxt      = SYNC_BYTE >> 1;
          bit_cnt_nxt = 3'd0;
          len_cnt_nxt = 8'd0;
        end else begin
          dout_nxt    = 1'b0;
          len_cnt_nxt = len_cnt + 8'd1;
        end
      end

      S_SYNC, S_DATA: begin
        if (bit_cnt == 3'd7) begin
          if (TXVALID) begin
            state_nxt   = S_DATA;
            dout_nxt    = TXDATA[0];
            sh_nxt      = TXDATA >> 1;
            bit_cnt_nxt = 3'd0;
          end else begin
            // No byte offered: trail at the opposite level of the last bit.
            state_nxt     = S_TRAIL;
            trail_lvl_nxt = ~DTXHSP;
            dout_nxt      = ~DTXHSP;
            len_cnt_nxt   = 8'd1;
          end
        end else begin
          dout_nxt    = sh[0];
          sh_nxt      = sh >> 1;
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end

      S_TRAIL: begin
        if (len_cnt == HS_TRAIL_CYC) begin
          state_nxt   = S_IDLE;
          dout_nxt    = 1'b0;
          active_nxt  = 1'b0;
          len_cnt_nxt = 8'd0;
        end else begin
          dout_nxt    = trail_lvl;
          len_cnt_nxt = len_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        dout_nxt   = 1'b0;
        active_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mipi_hs_serializer.sv
// tb/tb_mipi_hs_serializer.sv - directed self-checking bench for mipi_hs_serializer
module tb_mipi_hs_serializer;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] txdata;
  logic       txvalid;
  logic       rdy_a, dout_a, act_a;
  logic       rdy_b, dout_b, act_b;

  logic       sel;
  logic       rdy_o, dout_o, act_o;

  int         n_assert;
  int         n_fail;

  logic [63:0] cap;
  int          cap_len;
  int          rdy_cnt;
  int          acc;
  int          first_rdy;
  int          prev_rdy;
  logic        spacing_ok;
  logic        timeout;
  logic [7:0]  pay [0:7];
  int          idle_cnt;
  logic        done;

  mipi_hs_serializer dut_a (
    .TxDDRClkHS (clk),
    .RST_N      (rst_n),
    .HS_SER_EN  (en_a),
    .TXDATA     (txdata),
    .TXVALID    (txvalid),
    .TXREADY    (rdy_a),
    .DTXHSP     (dout_a),
    .HS_ACTIVE  (act_a)
  );

  mipi_hs_serializer #(
    .HS_ZERO_CYC  (8'd1),
    .HS_TRAIL_CYC (8'd1)
  ) dut_b (
    .TxDDRClkHS (clk),
    .RST_N      (rst_n),
    .HS_SER_EN  (en_b),
    .TXDATA     (txdata),
    .TXVALID    (txvalid),
    .TXREADY    (rdy_b),
    .DTXHSP     (dout_b),
    .HS_ACTIVE  (act_b)
  );

  assign rdy_o  = sel ? rdy_b  : rdy_a;
  assign dout_o = sel ? dout_b : dout_a;
  assign act_o  = sel ? act_b  : act_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests one burst and records every active bit (first bit ends up in
  // the most significant captured position). Bytes pay[0..n-1] are offered
  // at successive slots; noisy drives random TXVALID/TXDATA off-slot.
  task automatic run_burst(input logic s, input int n, input logic hold, input logic noisy);
    int   idx;
    logic seen;
    cap = '0; cap_len = 0; rdy_cnt = 0; acc = 0;
    first_rdy = -1; prev_rdy = -1; spacing_ok = 1'b1; timeout = 1'b1;
    idx = 0; seen = 1'b0;
    sel = s;
    @(negedge clk);
    if (s) en_b = 1'b1; else en_a = 1'b1;
    txvalid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        en_a = 1'b0;
        en_b = 1'b0;
      end
      if (act_o) begin
        seen = 1'b1;
        cap = {cap[62:0], dout_o};
        cap_len++;
      end else if (seen) begin
        timeout = 1'b0;
        break;
      end
      if (rdy_o) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = cap_len - 1;
        else if ((cap_len - 1) - prev_rdy != 8) spacing_ok = 1'b0;
        prev_rdy = cap_len - 1;
        if (idx < n) begin
          txvalid = 1'b1;
          txdata  = pay[idx];
          idx++;
          acc++;
        end else begin
          txvalid = 1'b0;
        end
      end else if (noisy) begin
        txvalid = 1'($urandom_range(0, 1));
        txdata  = 8'($urandom);
      end else begin
        txvalid = 1'b0;
      end
    end
    txvalid = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sel      = 1'b0;
    rst_n    = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    txvalid  = 1'b0;
    txdata   = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset_dout_a", 64'(dout_a), 64'd0);
    chk("reset_act_a",  64'(act_a),  64'd0);
    chk("reset_rdy_a",  64'(rdy_a),  64'd0);
    chk("reset_act_b",  64'(act_b),  64'd0);

    // Reset mid-DATA: outputs drop between edges
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rdy_a) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t1_slot_seen", 64'(done), 64'd1);
    txvalid = 1'b1;
    txdata  = 8'hFF;
    @(negedge clk);
    txvalid = 1'b0;
    @(negedge clk);
    chk("t1_dout_before", 64'(dout_a), 64'd1);
    chk("t1_act_before",  64'(act_a),  64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_dout_rst", 64'(dout_a), 64'd0);
    chk("t1_act_rst",  64'(act_a),  64'd0);
    chk("t1_rdy_rst",  64'(rdy_a),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_idle_act",  64'(act_a),  64'd0);
    chk("t1_idle_dout", 64'(dout_a), 64'd0);

    // Two bytes A5, 3C with default parameters
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    run_burst(1'b0, 2, 1'b0, 1'b0);
    chk("t2_done", 64'(timeout), 64'd0);
    chk("t2_len",  64'(cap_len), 64'd48);
    chk("t2_bits", cap, {16'h0, 16'h0000, 8'b00011101, 8'b10100101, 8'b00111100, 8'b11111111});
    chk("t2_acc",  64'(acc), 64'd2);

    // Empty burst
    run_burst(1'b0, 0, 1'b0, 1'b0);
    chk("t3_done", 64'(timeout), 64'd0);
    chk("t3_len",  64'(cap_len), 64'd32);
    chk("t3_bits", cap, {32'h0, 16'h0000, 8'b00011101, 8'b00000000});
    chk("t3_rdy",  64'(rdy_cnt), 64'd1);

    // Four bytes: TXREADY cadence
    pay[0] = 8'h01;
    pay[1] = 8'h80;
    pay[2] = 8'hFF;
    pay[3] = 8'h5A;
    run_burst(1'b0, 4, 1'b0, 1'b0);
    chk("t4_done",    64'(timeout), 64'd0);
    chk("t4_len",     64'(cap_len), 64'd64);
    chk("t4_bits",    cap, {16'h0000, 8'b00011101, 8'b10000000, 8'b00000001, 8'hFF, 8'b01011010, 8'hFF});
    chk("t4_rdy_cnt", 64'(rdy_cnt), 64'd5);
    chk("t4_first",   64'(first_rdy), 64'd23);
    chk("t4_spacing", 64'(spacing_ok), 64'd1);
    chk("t4_acc",     64'(acc), 64'd4);

    // Off-slot TXVALID noise, HS_SER_EN held high
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    run_burst(1'b0, 2, 1'b1, 1'b1);
    chk("t5_done", 64'(timeout), 64'd0);
    chk("t5_len",  64'(cap_len), 64'd48);
    chk("t5_bits", cap, {16'h0, 16'h0000, 8'b00011101, 8'b10100101, 8'b00111100, 8'b11111111});
    idle_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (act_a) break;
      idle_cnt++;
    end
    chk("t5_idle_gap", 64'(idle_cnt), 64'd1);
    en_a = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!act_a) begin
        done = 1'b1;
        break;
      end
    end
    chk("t5_second_end", 64'(done), 64'd1);

    // Minimum zero/trail lengths, one byte FF
    pay[0] = 8'hFF;
    run_burst(1'b1, 1, 1'b0, 1'b0);
    chk("t6_done", 64'(timeout), 64'd0);
    chk("t6_len",  64'(cap_len), 64'd18);
    chk("t6_bits", cap, {46'h0, 1'b0, 8'b00011101, 8'hFF, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
